vld_data_tx: RTL and testbench
==============================

VLD_DATA_TX -- requirements
Module: vld_data_tx

Interface
REQ-001 SHALL have parameter DW, default 8, width of the data word.
REQ-002 SHALL have parameter DEPTH, default 4, total buffered words including the output register; legal range 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_vld  input  1  upstream word offered.
REQ-006 SHALL have port in_data  input  DW  upstream word.
REQ-007 SHALL have port in_rdy  output  1  block can accept a word this cycle.
REQ-008 SHALL have port vld  output  1  downstream word valid (registered).
REQ-009 SHALL have port data  output  DW  downstream word (registered).
REQ-010 SHALL have port rdy  input  1  downstream receiver accepts the word.
REQ-011 SHALL have port flush  input  1  synchronous discard of all buffered words.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  words held, including the output register.
REQ-013 SHALL have port err  output  1  sticky: an unacknowledged beat was dropped.

Function
REQ-014 SHALL accept a word on a clk edge when in_vld && in_rdy, and SHALL drop none.
REQ-015 SHALL drive in_rdy = (count < DEPTH) combinationally; at full, in_rdy stays low even if a pop occurs that cycle (no full bypass).
REQ-016 SHALL retire a word on a clk edge when vld && rdy.
REQ-017 SHALL emit words in acceptance order.
REQ-018 SHALL present a word accepted while count==0 on vld/data at the next edge (latency 1), with no combinational in->out path.
REQ-019 SHALL hold vld high and data unchanged while vld && !rdy, except under flush or rst.
REQ-020 SHALL load the next word into the output register on the same edge as a retire, giving back-to-back beats at full throughput with rdy held high.
REQ-021 SHALL drive data = 0 whenever vld = 0.
REQ-022 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; never below 0 or above DEPTH.
REQ-023 SHALL track occupancy as states EMPTY (count==0), ACTIVE (0<count<DEPTH) and FULL (count==DEPTH): EMPTY->ACTIVE on push; ACTIVE->FULL on push without pop at DEPTH-1; FULL->ACTIVE on pop; ACTIVE->EMPTY on pop without push at 1.
REQ-024 SHALL wrap the internal read/write pointers modulo DEPTH-1 for any DEPTH, including non-powers of two.
REQ-025 SHALL give flush priority over push and pop: on the flush edge, count->0, vld->0, data->0, and any in_vld that cycle is discarded. in_rdy is not forced low during flush.
REQ-026 SHALL accept new pushes normally on the cycle after flush deasserts.

Reset
REQ-027 SHALL on rst assertion, immediately and independent of clk, set vld=0, data=0, count=0, err=0 and the pointers to 0; in_rdy is consequently 1.
REQ-028 SHALL discard all buffered words on rst asserted mid-transfer; no word accepted before reset is emitted after it.
REQ-029 SHALL resume operation on the first clk edge after rst deasserts.

Configuration
REQ-030 SHALL use macro VLD_DATA_TX_DROP_CHECK_EN.
REQ-031 SHALL with VLD_DATA_TX_DROP_CHECK_EN defined: set err at the flush edge when vld && !rdy in that cycle, and hold err until rst.
REQ-032 SHALL with VLD_DATA_TX_DROP_CHECK_EN undefined: keep the err port present and tie it to 0.

Verification
REQ-033 SHALL cover: DW=8, DEPTH=4, rdy=1, push 0x11,0x22,0x33 back-to-back -> vld high for 3 consecutive cycles starting 1 cycle after the first push, data 0x11,0x22,0x33 in order.
REQ-034 SHALL cover: rdy=0, push 5 words -> in_rdy low after the 4th accept, count==4, data holds the first word; set rdy=1 -> 4 words drain in order, in_rdy returns high after the first pop.
REQ-035 SHALL cover: count==4 with push and pop in the same cycle -> push not accepted, count==3.
REQ-036 SHALL cover: count==2, vld=1, rdy=0, pulse flush with in_vld=1 -> next cycle count==0, vld==0, data==0, err==1 (macro defined) or err==0 (undefined).
REQ-037 SHALL cover: assert rst mid-stream between clk edges -> vld, count, err go to 0 immediately; after release, push 0xA5 -> vld with 0xA5 one cycle later, no pre-reset word emitted.
REQ-038 SHALL cover: concurrent checker throughout all scenarios -> vld && !rdy implies vld && data stable next cycle unless flush or rst, and !vld implies data==0.

Source files
------------

// File: rtl/vld_data_tx.sv
// Valid/ready transmit buffer: DEPTH words total, the head word lives in a registered output stage.
// Define VLD_DATA_TX_DROP_CHECK_EN to make err latch when a flush discards a stalled output word.
module vld_data_tx #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic [DW-1:0]                in_data,
  output logic                         in_rdy,
  output logic                         vld,
  output logic [DW-1:0]                data,
  input  logic                         rdy,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int BD = DEPTH - 1;
  localparam int PW = (BD > 1) ? $clog2(BD) : 1;
  localparam logic [PW-1:0] PLAST = PW'(BD - 1);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] mem [BD];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          push, pop, buf_has, to_out, to_buf;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  assign in_rdy  = (state != S_FULL);
  assign push    = in_vld && in_rdy;
  assign pop     = vld && rdy;
  assign buf_has = (count > CW'(1));
  // a push bypasses the buffer only when the output stage is (or is becoming) empty
  assign to_out  = push && (!vld || (pop && !buf_has));
  assign to_buf  = push && !to_out;

  always_ff @(posedge clk) begin
    if (to_buf && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_EMPTY;
      count  <= '0;
      vld    <= 1'b0;
      data   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      state  <= S_EMPTY;
      count  <= '0;
      vld    <= 1'b0;
      data   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (to_buf) wr_ptr <= nxt(wr_ptr);

      if (pop && buf_has) begin
        data   <= mem[rd_ptr];
        rd_ptr <= nxt(rd_ptr);
      end else if (to_out) begin
        vld  <= 1'b1;
        data <= in_data;
      end else if (pop) begin
        vld  <= 1'b0;
        data <= '0;
      end

      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      case (state)
        S_EMPTY:  if (push) state <= S_ACTIVE;
        S_ACTIVE: begin
          if (push && !pop && count == CW'(DEPTH-1)) state <= S_FULL;
          else if (pop && !push && count == CW'(1))  state <= S_EMPTY;
        end
        S_FULL:   if (pop) state <= S_ACTIVE;
        default:  state <= S_EMPTY;
      endcase
    end
  end

`ifdef VLD_DATA_TX_DROP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err <= 1'b0;
    else if (flush && vld && !rdy) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vld_data_tx.sv
// Bench for vld_data_tx: queue model of buffered words checked every cycle, plus literal checkpoints.
module tb_vld_data_tx;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
`ifdef VLD_DATA_TX_DROP_CHECK_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk, rst, in_vld, in_rdy, vld, rdy, flush, err;
  logic [DW-1:0] in_data, data;
  logic [CW-1:0] count;

  vld_data_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .vld(vld), .data(data), .rdy(rdy), .flush(flush), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  bit err_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, step the model across the edge, then check everything.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    bit stall, p, u;
    logic [DW-1:0] pdata;
    in_vld = v; in_data = d; rdy = r; flush = f;
    stall = vld && !r && !f;
    pdata = data;
    if (f) begin
      if (DROP && q.size() > 0 && !r) err_m = 1'b1;
      q.delete();
    end else begin
      p = (q.size() > 0) && r;
      u = v && (q.size() < DEPTH);
      if (p) void'(q.pop_front());
      if (u) q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("vld",    32'(vld),    32'(q.size() > 0));
    chk("data",   32'(data),   (q.size() > 0) ? 32'(q[0]) : 32'd0);
    chk("count",  32'(count),  32'(q.size()));
    chk("in_rdy", 32'(in_rdy), 32'(q.size() < DEPTH));
    chk("err",    32'(err),    32'(err_m));
    if (!vld) chk("idle_data_zero", 32'(data), 32'd0);
    if (stall) begin
      chk("stall_vld",  32'(vld),  32'd1);
      chk("stall_data", 32'(data), 32'(pdata));
    end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; rdy = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chk("reset_vld", 32'(vld), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back with rdy high
    drive(1, 8'h11, 1, 0); chk("b2b_0", 32'(data), 32'h11);
    drive(1, 8'h22, 1, 0); chk("b2b_1", 32'(data), 32'h22);
    drive(1, 8'h33, 1, 0); chk("b2b_2", 32'(data), 32'h33);
    drive(0, 8'h00, 1, 0); chk("b2b_end", 32'(vld), 32'd0);

    // backpressure fill and drain
    drive(1, 8'h41, 0, 0);
    drive(1, 8'h42, 0, 0);
    drive(1, 8'h43, 0, 0);
    drive(1, 8'h44, 0, 0);
    chk("full_in_rdy", 32'(in_rdy), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", 32'(data), 32'h41);
    drive(1, 8'h45, 0, 0); chk("full_no_accept", 32'(count), 32'd4);
    drive(0, 8'h00, 1, 0);
    chk("drain_1", 32'(data), 32'h42);
    chk("drain_rdy_back", 32'(in_rdy), 32'd1);
    drive(0, 8'h00, 1, 0); chk("drain_2", 32'(data), 32'h43);
    drive(0, 8'h00, 1, 0); chk("drain_3", 32'(data), 32'h44);
    drive(0, 8'h00, 1, 0); chk("drain_empty", 32'(vld), 32'd0);

    // full with simultaneous push and pop: no full bypass
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h51 + i), 0, 0);
    drive(1, 8'h55, 1, 0);
    chk("full_pp_count", 32'(count), 32'd3);
    chk("full_pp_head", 32'(data), 32'h52);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1, 0);

    // flush while stalled, in_vld discarded
    drive(1, 8'h61, 0, 0);
    drive(1, 8'h62, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd2);
    drive(1, 8'h63, 0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_vld", 32'(vld), 32'd0);
    chk("flush_data", 32'(data), 32'd0);
    chk("flush_err", 32'(err), 32'(DROP));
    drive(1, 8'h64, 1, 0); chk("post_flush", 32'(data), 32'h64);
    drive(0, 8'h00, 1, 0);

    // async reset mid-stream
    drive(1, 8'h71, 0, 0);
    drive(1, 8'h72, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(vld), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    q.delete();
    err_m = 1'b0;
    in_vld = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 8'hA5, 1, 0);
    chk("post_rst_vld", 32'(vld), 32'd1);
    chk("post_rst_data", 32'(data), 32'hA5);
    drive(0, 8'h00, 1, 0); chk("post_rst_empty", 32'(vld), 32'd0);

    // mixed traffic exercising pointer wrap
    for (int i = 0; i < 40; i++)
      drive(i % 3 != 2, 8'(8'h80 + i), i % 4 != 0, i == 25);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0);
    chk("final_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
